id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the reduced RISC-V pipeline. It sits directly upstream of the ALU and drives the ALU's `ALUop1`, `regOp2`, `ImmOp`, `ALUctrl` and `ALUsrc` inputs. It latches decoded operands and controls each cycle, with stall (hold) and flush (bubble) control. It also resolves RAW hazards by forwarding from the memory and writeback stages, and flags load-use hazards back to the hazard logic.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/id_ex_stage_if.sv | 47 ++++
 rtl/forward_mux.sv | 42 ++++
 rtl/id_ex_stage.sv | 97 +++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the reduced RISC-V pipeline: result select, ALU ops,
// forward selects and the E-stage control bundle with its bubble value.
package pipeline_pkg;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    logic       alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/execute bus: D-stage inputs, M/W forward sources and E-stage outputs.
// master drives D and M/W sources; slave (the stage) drives the E outputs.
interface id_ex_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  import pipeline_pkg::*;

  // decode side
  logic [DATA_WIDTH-1:0] RD1D, RD2D, ImmExtD, PCD;
  logic [ADDR_WIDTH-1:0] Rs1D, Rs2D, RdD;
  logic [2:0]            ALUctrlD;
  logic                  ALUsrcD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]            ResultSrcD;
  // forward sources
  logic [DATA_WIDTH-1:0] ALUResultM, ResultW;
  logic [ADDR_WIDTH-1:0] RdM, RdW;
  logic                  RegWriteM, RegWriteW;
  // execute side
  logic [DATA_WIDTH-1:0] ALUop1, regOp2, ImmOp, WriteDataE, PCE;
  logic [2:0]            ALUctrl;
  logic                  ALUsrc;
  logic [ADDR_WIDTH-1:0] Rs1E, Rs2E, RdE;
  logic                  RegWriteE, MemWriteE, BranchE, JumpE;
  logic [1:0]            ResultSrcE;
  logic                  LoadUseHazard;
  fwd_sel_e              ForwardAE, ForwardBE;

  modport master (
    output RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUctrlD, ALUsrcD,
           RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD,
           ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    input  ALUop1, regOp2, ImmOp, WriteDataE, PCE, ALUctrl, ALUsrc,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, BranchE, JumpE,
           ResultSrcE, LoadUseHazard, ForwardAE, ForwardBE
  );

  modport slave (
    input  RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUctrlD, ALUsrcD,
           RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD,
           ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    output ALUop1, regOp2, ImmOp, WriteDataE, PCE, ALUctrl, ALUsrc,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, BranchE, JumpE,
           ResultSrcE, LoadUseHazard, ForwardAE, ForwardBE
  );

endinterface

// File: rtl/forward_mux.sv
// Per-operand RAW forwarding: picks M result, else W result, else the
// latched register value. Index 0 never forwards.
// Ports: rs/reg_val (E-stage operand), rd_m/reg_write_m/result_m,
//        rd_w/reg_write_w/result_w, sel (chosen source), val (operand).
module forward_mux
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] reg_val,
  input  logic [ADDR_WIDTH-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [DATA_WIDTH-1:0] result_m,
  input  logic [ADDR_WIDTH-1:0] rd_w,
  input  logic                  reg_write_w,
  input  logic [DATA_WIDTH-1:0] result_w,
  output fwd_sel_e              sel,
  output logic [DATA_WIDTH-1:0] val
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs);

  // M is the younger producer, so it wins over W
  always_comb begin
    sel = FWD_REG;
    val = reg_val;
    if (hit_m) begin
      sel = FWD_M;
      val = result_m;
    end else if (hit_w) begin
      sel = FWD_W;
      val = result_w;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with stall/flush, M/W forwarding of
// both source operands and load-use hazard detection.
// Ports: clk, rst_n (async, active-low), stall (hold), flush (bubble),
//        bus (slave side of id_ex_stage_if: D inputs, M/W sources, E outputs).
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  id_ex_stage_if.slave  bus
);

  ctrl_t                 ctrl_q;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, imm_q, pc_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] op2;

  // E-stage registers; a bubble is the all-zero state, same as reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      ctrl_q <= CTRL_BUBBLE;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (!stall) begin
      ctrl_q <= '{reg_write:  bus.RegWriteD,
                  mem_write:  bus.MemWriteD,
                  branch:     bus.BranchD,
                  jump:       bus.JumpD,
                  result_src: bus.ResultSrcD,
                  alu_ctrl:   bus.ALUctrlD,
                  alu_src:    bus.ALUsrcD};
      rd1_q  <= bus.RD1D;
      rd2_q  <= bus.RD2D;
      imm_q  <= bus.ImmExtD;
      pc_q   <= bus.PCD;
      rs1_q  <= bus.Rs1D;
      rs2_q  <= bus.Rs2D;
      rd_q   <= bus.RdD;
    end
  end

  forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .rs          (rs1_q),
    .reg_val     (rd1_q),
    .rd_m        (bus.RdM),
    .reg_write_m (bus.RegWriteM),
    .result_m    (bus.ALUResultM),
    .rd_w        (bus.RdW),
    .reg_write_w (bus.RegWriteW),
    .result_w    (bus.ResultW),
    .sel         (bus.ForwardAE),
    .val         (bus.ALUop1)
  );

  forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .rs          (rs2_q),
    .reg_val     (rd2_q),
    .rd_m        (bus.RdM),
    .reg_write_m (bus.RegWriteM),
    .result_m    (bus.ALUResultM),
    .rd_w        (bus.RdW),
    .reg_write_w (bus.RegWriteW),
    .result_w    (bus.ResultW),
    .sel         (bus.ForwardBE),
    .val         (op2)
  );

  assign bus.regOp2     = op2;
  assign bus.WriteDataE = op2;
  assign bus.ImmOp      = imm_q;
  assign bus.PCE        = pc_q;
  assign bus.Rs1E       = rs1_q;
  assign bus.Rs2E       = rs2_q;
  assign bus.RdE        = rd_q;
  assign bus.ALUctrl    = ctrl_q.alu_ctrl;
  assign bus.ALUsrc     = ctrl_q.alu_src;
  assign bus.RegWriteE  = ctrl_q.reg_write;
  assign bus.MemWriteE  = ctrl_q.mem_write;
  assign bus.BranchE    = ctrl_q.branch;
  assign bus.JumpE      = ctrl_q.jump;
  assign bus.ResultSrcE = ctrl_q.result_src;

  // load in E whose destination is read by the instruction now in D
  assign bus.LoadUseHazard = (ctrl_q.result_src == RESULT_LOAD) && (rd_q != '0) &&
                             ((rd_q == bus.Rs1D) || (rd_q == bus.Rs2D));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: behavioural model of the E-stage contents plus
// forwarding/hazard rules, checked every negedge, with literal checks.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst_n, stall, flush;
  int   n_vec = 0;
  int   n_fail = 0;
  bit   cmp_en = 1'b0;

  id_ex_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // model of what the E stage currently holds
  typedef struct {
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  aluc;
    logic        alus, rw, mw, br, j;
    logic [1:0]  rsrc;
  } e_t;
  e_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      m = '{default: 0};
    end else if (!stall) begin
      m.rd1 = bus.RD1D;  m.rd2 = bus.RD2D;  m.imm = bus.ImmExtD; m.pc = bus.PCD;
      m.rs1 = bus.Rs1D;  m.rs2 = bus.Rs2D;  m.rd = bus.RdD;
      m.aluc = bus.ALUctrlD; m.alus = bus.ALUsrcD; m.rw = bus.RegWriteD;
      m.mw = bus.MemWriteD;  m.br = bus.BranchD;   m.j = bus.JumpD;
      m.rsrc = bus.ResultSrcD;
    end
  end

  function automatic logic [1:0] exp_sel(input logic [4:0] rs);
    if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] rs, input logic [31:0] regv);
    case (exp_sel(rs))
      2'b10:   return bus.ALUResultM;
      2'b01:   return bus.ResultW;
      default: return regv;
    endcase
  endfunction

  function automatic logic exp_lu();
    return (m.rsrc == 2'b01) && (m.rd != 5'd0) && (m.rd == bus.Rs1D || m.rd == bus.Rs2D);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("ALUop1",     bus.ALUop1,        exp_val(m.rs1, m.rd1));
      chk("regOp2",     bus.regOp2,        exp_val(m.rs2, m.rd2));
      chk("WriteDataE", bus.WriteDataE,    exp_val(m.rs2, m.rd2));
      chk("ForwardAE",  32'(bus.ForwardAE), 32'(exp_sel(m.rs1)));
      chk("ForwardBE",  32'(bus.ForwardBE), 32'(exp_sel(m.rs2)));
      chk("ImmOp",      bus.ImmOp,         m.imm);
      chk("PCE",        bus.PCE,           m.pc);
      chk("Rs1E",       32'(bus.Rs1E),     32'(m.rs1));
      chk("Rs2E",       32'(bus.Rs2E),     32'(m.rs2));
      chk("RdE",        32'(bus.RdE),      32'(m.rd));
      chk("ALUctrl",    32'(bus.ALUctrl),  32'(m.aluc));
      chk("ALUsrc",     32'(bus.ALUsrc),   32'(m.alus));
      chk("RegWriteE",  32'(bus.RegWriteE), 32'(m.rw));
      chk("MemWriteE",  32'(bus.MemWriteE), 32'(m.mw));
      chk("BranchE",    32'(bus.BranchE),  32'(m.br));
      chk("JumpE",      32'(bus.JumpE),    32'(m.j));
      chk("ResultSrcE", 32'(bus.ResultSrcE), 32'(m.rsrc));
      chk("LoadUse",    32'(bus.LoadUseHazard), 32'(exp_lu()));
    end
  end

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.RD1D = '0; bus.RD2D = '0; bus.ImmExtD = '0; bus.PCD = '0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
    bus.ALUctrlD = ALU_ADD; bus.ALUsrcD = 1'b0; bus.RegWriteD = 1'b0;
    bus.MemWriteD = 1'b0; bus.BranchD = 1'b0; bus.JumpD = 1'b0;
    bus.ResultSrcD = RESULT_ALU;
    bus.ALUResultM = '0; bus.RdM = '0; bus.RegWriteM = 1'b0;
    bus.ResultW = '0; bus.RdW = '0; bus.RegWriteW = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_inputs();
    #1;
    chk("reset_ALUop1", bus.ALUop1, 32'h0);
    chk("reset_PCE", bus.PCE, 32'h0);
    chk("reset_LoadUse", 32'(bus.LoadUseHazard), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

    // capture latency
    bus.PCD = 32'h100; bus.ImmExtD = 32'h4;
    #1;
    chk("lat_PCE_before", bus.PCE, 32'h0);
    step();
    chk("lat_PCE", bus.PCE, 32'h100);
    chk("lat_ImmOp", bus.ImmOp, 32'h4);

    // M has priority over W
    bus.Rs1D = 5'd5; bus.RD1D = 32'h1;
    step();
    bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.ALUResultM = 32'hAA;
    bus.RdW = 5'd5; bus.RegWriteW = 1'b1; bus.ResultW = 32'hBB;
    #1;
    chk("fwd_m_prio", bus.ALUop1, 32'hAA);
    bus.RegWriteM = 1'b0;
    #1;
    chk("fwd_w", bus.ALUop1, 32'hBB);
    bus.RegWriteW = 1'b0;
    #1;
    chk("fwd_none", bus.ALUop1, 32'h1);

    // x0 is never forwarded
    bus.Rs2D = 5'd0; bus.RD2D = 32'h0;
    step();
    bus.RdM = 5'd0; bus.RegWriteM = 1'b1; bus.ALUResultM = 32'hFF;
    #1;
    chk("x0_regOp2", bus.regOp2, 32'h0);
    chk("x0_WriteData", bus.WriteDataE, 32'h0);
    bus.RegWriteM = 1'b0;

    // stall holds, flush beats stall, repeated flush stays bubble
    bus.ALUctrlD = ALU_SUB; bus.ImmExtD = 32'h7FF; bus.RegWriteD = 1'b1;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ALUctrlD = 3'(i + 2); bus.ImmExtD = 32'(i * 16 + 3); bus.RegWriteD = 1'(i);
      step();
      chk("stall_ALUctrl", 32'(bus.ALUctrl), 32'h1);
      chk("stall_ImmOp", bus.ImmOp, 32'h7FF);
      chk("stall_RegWriteE", 32'(bus.RegWriteE), 32'h1);
    end
    flush = 1'b1;
    step();
    chk("flush_ALUctrl", 32'(bus.ALUctrl), 32'h0);
    chk("flush_RegWriteE", 32'(bus.RegWriteE), 32'h0);
    chk("flush_ImmOp", bus.ImmOp, 32'h0);
    stall = 1'b0;
    step();
    chk("flush2_ImmOp", bus.ImmOp, 32'h0);
    flush = 1'b0;
    clear_inputs();

    // load-use detection
    bus.ResultSrcD = RESULT_LOAD; bus.RdD = 5'd7; bus.RegWriteD = 1'b1;
    step();
    bus.Rs1D = 5'd3; bus.Rs2D = 5'd7;
    #1;
    chk("lu_rs2_hit", 32'(bus.LoadUseHazard), 32'h1);
    bus.Rs2D = 5'd3;
    #1;
    chk("lu_miss", 32'(bus.LoadUseHazard), 32'h0);
    bus.RdD = 5'd0;
    step();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0;
    #1;
    chk("lu_rd0", 32'(bus.LoadUseHazard), 32'h0);

    // reset mid-operation
    bus.RD1D = 32'h10; bus.Rs1D = 5'd7; bus.RdD = 5'd7; bus.PCD = 32'h44;
    step();
    chk("pre_rst_ALUop1", bus.ALUop1, 32'h10);
    chk("pre_rst_LoadUse", 32'(bus.LoadUseHazard), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_ALUop1", bus.ALUop1, 32'h0);
    chk("rst_PCE", bus.PCE, 32'h0);
    chk("rst_LoadUse", 32'(bus.LoadUseHazard), 32'h0);
    #1;
    rst_n = 1'b1;
    clear_inputs();

    // mixed patterns, checked by the model every cycle
    for (int i = 0; i < 24; i++) begin
      bus.Rs1D = 5'(i % 4);       bus.Rs2D = 5'((i + 1) % 4);
      bus.RdD = 5'((i * 3) % 4);  bus.RD1D = 32'(i * 32'h1111);
      bus.RD2D = 32'(~i);         bus.ImmExtD = 32'(i << 4);
      bus.PCD = 32'(i * 4);       bus.ResultSrcD = (i % 3 == 0) ? RESULT_LOAD : RESULT_PC4;
      bus.ALUctrlD = 3'(i);       bus.ALUsrcD = 1'(i >> 1);
      bus.RegWriteD = 1'(i);      bus.MemWriteD = 1'(i >> 2);
      bus.BranchD = 1'(i >> 3);   bus.JumpD = 1'(i >> 4);
      bus.RdM = 5'((i + 2) % 4);  bus.RegWriteM = 1'(i % 3 != 1);
      bus.ALUResultM = 32'hA000 + 32'(i);
      bus.RdW = 5'((i + 1) % 4);  bus.RegWriteW = 1'(i % 2);
      bus.ResultW = 32'hB000 + 32'(i);
      stall = (i % 5 == 2);
      flush = (i % 7 == 3);
      step();
    end
    stall = 1'b0; flush = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
